// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared types and constants
// for the SRAM-backed streaming FIFO.
package sram_fifo_pkg;

  localparam int OBUF_DEPTH = 2;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_WR,
    OP_RD
  } port_op_e;

endpackage

// File: rtl/sram_fifo_obuf.sv
// sram_fifo_obuf: 2-entry output buffer that
// absorbs SRAM read data and feeds the consumer.
module sram_fifo_obuf
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cap,
  input  logic [DATA_WIDTH-1:0] i_cap_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic [1:0]            o_cnt
);

  logic [DATA_WIDTH-1:0] r_data [OBUF_DEPTH];
  logic                  r_head;
  logic [1:0]            r_cnt;
  logic                  w_tail;
  logic                  w_pop;

  assign w_tail  = r_head ^ r_cnt[0];
  assign w_pop   = (r_cnt != 2'd0) && i_ready;
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_data[r_head];
  assign o_cnt   = r_cnt;

  // capture at the tail, pop at the head; both may happen together
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_head    <= 1'b0;
      r_cnt     <= 2'd0;
    end else begin
      if (i_cap) r_data[w_tail] <= i_cap_data;
      if (w_pop) r_head <= ~r_head;
      unique case ({i_cap, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: arbitrates the single SRAM port between
// producer writes and prefetch reads into the output buffer.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam logic [ADDR_WIDTH:0] MEM_FULL =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_mem_cnt;
  logic                  r_rd_pend;
  logic [1:0]            w_obuf_cnt;
  logic [2:0]            w_occ;
  logic                  w_rd_go;
  port_op_e              w_op;

  assign w_occ   = {1'b0, w_obuf_cnt} + {2'b00, r_rd_pend};
  assign w_rd_go = rst_n && (r_mem_cnt != '0) && (w_occ < 3'd2);

  assign in_ready = rst_n && !w_rd_go && (r_mem_cnt != MEM_FULL);

  assign count = {1'b0, r_mem_cnt}
               + {{(ADDR_WIDTH+1){1'b0}}, r_rd_pend}
               + {{ADDR_WIDTH{1'b0}}, w_obuf_cnt};

  // one port op per cycle, prefetch reads win
  always_comb begin
    w_op = OP_IDLE;
    unique case (1'b1)
      w_rd_go:               w_op = OP_RD;
      (in_valid && in_ready): w_op = OP_WR;
      default:               w_op = OP_IDLE;
    endcase
  end

  assign sram_we   = (w_op == OP_WR);
  assign sram_addr = (w_op == OP_WR) ? r_wr_ptr : r_rd_ptr;
  assign sram_din  = (w_op == OP_WR) ? in_data : '0;

  // pointer, occupancy and in-flight read bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_mem_cnt <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= (w_op == OP_RD);
      unique case (w_op)
        OP_RD: begin
          r_rd_ptr  <= r_rd_ptr + 1'b1;
          r_mem_cnt <= r_mem_cnt - 1'b1;
        end
        OP_WR: begin
          r_wr_ptr  <= r_wr_ptr + 1'b1;
          r_mem_cnt <= r_mem_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  sram_fifo_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cap      (r_rd_pend),
    .i_cap_data (sram_dout),
    .o_valid    (out_valid),
    .o_data     (out_data),
    .i_ready    (out_ready),
    .o_cnt      (w_obuf_cnt)
  );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: controller plus a behavioural
// single-port SRAM, checked against a reference queue.
module tb_sram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic [5:0] count;
  logic       sram_we;
  logic [3:0] sram_addr;
  logic [7:0] sram_din;
  logic [7:0] sram_dout;

  logic [7:0] mem [16];

  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  int n_acc = 0;
  logic [3:0] wr_model = '0;
  logic [7:0] sbq [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_din;
    sram_dout <= mem[sram_addr];
  end

  sram_fifo_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       irdy;
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic       ov;
    logic [7:0] od;
    logic [5:0] cnt;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_count", count, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_din", sram_din, 0);
    rst_n = 1'b1;
    sbq.delete();
    exp_cnt = 0;
    wr_model = '0;
  endtask

  task automatic tick();
    logic acc, pop;
    #1;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    chk("we_vs_accept", sram_we, acc);
    if (pop) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pop_empty: got %0h expected none", out_data);
      end else begin
        chk("out_data", out_data, sbq.pop_front());
      end
      exp_cnt--;
    end
    if (acc) begin
      chk("wr_addr", sram_addr, wr_model);
      chk("wr_din", sram_din, in_data);
      wr_model++;
      sbq.push_back(in_data);
      n_acc++;
      exp_cnt++;
    end
    @(posedge clk);
    #1;
    chk("count", count, exp_cnt);
  endtask

  task automatic drain(input int budget);
    int cyc;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_cnt != 0 && cyc < budget) begin
      tick();
      cyc++;
    end
    chk("drain_done", exp_cnt, 0);
    chk("drain_queue", sbq.size(), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int k, base, cyc;
    vt[0]  = '{1, 8'hAA, 0, 1, 1, 0, 8'hAA, 0, 8'h00, 0};
    vt[1]  = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1};
    vt[2]  = '{0, 8'h00, 0, 1, 0, 1, 8'h00, 0, 8'h00, 1};
    vt[3]  = '{0, 8'h00, 0, 1, 0, 1, 8'h00, 1, 8'hAA, 1};
    vt[4]  = '{0, 8'h00, 1, 1, 0, 1, 8'h00, 1, 8'hAA, 1};
    vt[5]  = '{0, 8'h00, 0, 1, 0, 1, 8'h00, 0, 8'h00, 0};
    vt[6]  = '{1, 8'h55, 0, 1, 1, 1, 8'h55, 0, 8'h00, 0};
    vt[7]  = '{1, 8'h66, 0, 0, 0, 1, 8'h00, 0, 8'h00, 1};
    vt[8]  = '{1, 8'h66, 0, 1, 1, 2, 8'h66, 0, 8'h00, 1};
    vt[9]  = '{0, 8'h00, 0, 0, 0, 2, 8'h00, 1, 8'h55, 2};
    vt[10] = '{0, 8'h00, 1, 1, 0, 3, 8'h00, 1, 8'h55, 2};
    vt[11] = '{0, 8'h00, 1, 1, 0, 3, 8'h00, 1, 8'h66, 1};
    vt[12] = '{0, 8'h00, 0, 1, 0, 3, 8'h00, 0, 8'h00, 0};

    do_reset();

    for (int i = 0; i < 13; i++) begin
      in_valid = vt[i].iv;
      in_data = vt[i].id;
      out_ready = vt[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, vt[i].irdy);
      chk($sformatf("v%0d_we", i), sram_we, vt[i].we);
      chk($sformatf("v%0d_addr", i), sram_addr, vt[i].addr);
      chk($sformatf("v%0d_din", i), sram_din, vt[i].din);
      chk($sformatf("v%0d_out_valid", i), out_valid, vt[i].ov);
      if (vt[i].ov)
        chk($sformatf("v%0d_out_data", i), out_data, vt[i].od);
      chk($sformatf("v%0d_count", i), count, vt[i].cnt);
      @(posedge clk);
      #1;
    end

    // fill to full with the consumer stalled
    do_reset();
    in_valid = 1'b1;
    base = n_acc;
    cyc = 0;
    while (n_acc - base < 18 && cyc < 200) begin
      in_data = 8'(n_acc - base);
      tick();
      cyc++;
    end
    chk("fill_accepts", n_acc - base, 18);
    in_data = 8'hEE;
    repeat (3) begin
      chk("full_in_ready", in_ready, 0);
      tick();
    end
    chk("full_count", count, 18);
    chk("full_out_valid", out_valid, 1);
    chk("full_head", out_data, 8'h00);
    drain(200);

    // continuous push and pop across pointer wraps
    do_reset();
    in_valid = 1'b1;
    out_ready = 1'b1;
    base = n_acc;
    cyc = 0;
    while (n_acc - base < 40 && cyc < 400) begin
      in_data = 8'h40 + 8'(n_acc - base);
      tick();
      cyc++;
    end
    chk("stream_accepts", n_acc - base, 40);
    drain(200);

    // reset lands on the capture of an issued read
    do_reset();
    in_valid = 1'b1;
    in_data = 8'h99;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_in_ready2", in_ready, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid2", out_valid, 0);
    rst_n = 1'b1;
    sbq.delete();
    exp_cnt = 0;
    wr_model = '0;
    in_valid = 1'b1;
    in_data = 8'h77;
    #1;
    chk("post_rst_addr", sram_addr, 0);
    chk("post_rst_we", sram_we, 1);
    tick();
    drain(50);

    // random throttling on both sides
    do_reset();
    base = n_acc;
    cyc = 0;
    while (n_acc - base < 1000 && cyc < 20000) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    chk("rand_accepts", n_acc - base, 1000);
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
